// File: rtl/sync_filter_pkg.sv
// Shared types and helpers for the sync_filter_bank synchroniser slice.
// Optional sticky flags are enabled in the top with SYNC_FILTER_BANK_STICKY_EN.
package sync_filter_pkg;

  localparam int STAGES_MIN = 2;

  typedef struct packed {
    logic rise;
    logic fall;
  } chan_evt_t;

  // Counter width that can hold 0..filt; never narrower than one bit.
  function automatic int cnt_width(input int filt);
    if (filt < 1) begin
      return 1;
    end else begin
      return $clog2(filt + 1);
    end
  endfunction

endpackage

// File: rtl/sync_filter_chan.sv
// One synchroniser channel: flop chain, persistence filter and registered edge pulses.
// Instantiated per bit by sync_filter_bank.
module sync_filter_chan
  import sync_filter_pkg::*;
#(
  parameter int STAGES = 2,
  parameter int FILT   = 1
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      d,
  output logic      q,
  output chan_evt_t evt
);

  localparam int             CW       = cnt_width(FILT);
  localparam logic [CW-1:0]  CNT_LAST = CW'(FILT - 1);

  generate
    if (STAGES < STAGES_MIN) begin : g_bad_stages
      $error("sync_filter_chan: STAGES must be at least 2");
    end
    if (FILT < 1) begin : g_bad_filt
      $error("sync_filter_chan: FILT must be at least 1");
    end
  endgenerate

  logic [STAGES-1:0] sync_r;
  logic              y_s;
  logic [CW-1:0]     cnt_r;
  logic [CW-1:0]     cnt_s;
  logic              q_r;
  logic              q_s;
  chan_evt_t         evt_r;
  chan_evt_t         evt_s;

  // Metastability chain: a plain shift register, each stage feeding only the next.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_r <= '0;
    end else begin
      sync_r <= {sync_r[STAGES-2:0], d};
    end
  end

  assign y_s = sync_r[STAGES-1];

  // A new level is accepted only after FILT consecutive samples; any return to q restarts the count.
  always_comb begin
    cnt_s = '0;
    q_s   = q_r;
    evt_s = '0;
    if (y_s == q_r) begin
      cnt_s = '0;
    end else if (cnt_r == CNT_LAST) begin
      q_s        = y_s;
      evt_s.rise = y_s;
      evt_s.fall = ~y_s;
    end else begin
      cnt_s = cnt_r + 1'b1;
    end
  end

  // Filter state and edge pulses; pulses land on the same edge as the q update.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_r <= '0;
      q_r   <= 1'b0;
      evt_r <= '0;
    end else begin
      cnt_r <= cnt_s;
      q_r   <= q_s;
      evt_r <= evt_s;
    end
  end

  assign q   = q_r;
  assign evt = evt_r;

endmodule

// File: rtl/sync_filter_bank.sv
// WIDTH-channel bank of filtered level synchronisers for asynchronous inputs.
// Define SYNC_FILTER_BANK_STICKY_EN to add per-channel latched-change flags.
module sync_filter_bank
  import sync_filter_pkg::*;
#(
  parameter int WIDTH  = 1,
  parameter int STAGES = 2,
  parameter int FILT   = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
`ifdef SYNC_FILTER_BANK_STICKY_EN
  ,
  output logic [WIDTH-1:0] sticky,
  input  logic [WIDTH-1:0] sticky_clr
`endif
);

  chan_evt_t chan_evt_s [WIDTH];

  generate
    for (genvar i = 0; i < WIDTH; i++) begin : g_chan
      sync_filter_chan #(
        .STAGES (STAGES),
        .FILT   (FILT)
      ) u_chan (
        .clk   (clk),
        .reset (reset),
        .d     (d[i]),
        .q     (q[i]),
        .evt   (chan_evt_s[i])
      );
      assign rise[i] = chan_evt_s[i].rise;
      assign fall[i] = chan_evt_s[i].fall;
    end
  endgenerate

`ifdef SYNC_FILTER_BANK_STICKY_EN
  logic [WIDTH-1:0] sticky_r;

  // Latched change flags; a pulse in the clearing cycle wins so no event is lost.
  always_ff @(posedge clk) begin
    if (reset) begin
      sticky_r <= '0;
    end else begin
      sticky_r <= (sticky_r & ~sticky_clr) | rise | fall;
    end
  end

  assign sticky = sticky_r;
`endif

endmodule
